// File: rtl/sound_event_scheduler.sv
// Sound-effect request scheduler: coalesces game requests into a pending set and
// issues the highest-priority effect to the buzzer player, with a silence gap between effects.
module sound_event_scheduler #(
    parameter int GAP_CYCLES  = 5000000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] req_i,
    input  logic       mute_i,
    input  logic       player_busy_i,
    input  logic       clr_err_i,
    output logic [2:0] sound_code_o,
    output logic       play_sound_o,
    output logic [6:0] pending_o,
    output logic       sched_busy_o,
    output logic       timeout_err_o
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_PLAYING,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [AW-1:0]   ack_cnt_q;
    logic [6:0]      pending_q;
    logic [6:0]      pending_d;
    logic [6:0]      issue_clear;
    logic [2:0]      sound_code_q;
    logic            play_sound_q;
    logic            timeout_err_q;

    // Highest set bit wins; code is bit index + 1, 0 when nothing is pending.
    function automatic logic [2:0] top_code(input logic [6:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) c = 3'(i + 1);
        end
        return c;
    endfunction

    always_comb begin
        issue_clear = '0;
        for (int i = 0; i < 7; i++) begin
            issue_clear[i] = (state_q == S_ISSUE) && (sound_code_q == 3'(i + 1));
        end
        if (mute_i) begin
            pending_d = '0;
        end else if (req_i[6]) begin
            pending_d = 7'b1000000;
        end else begin
            pending_d = (pending_q | req_i) & ~issue_clear;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            gap_cnt_q     <= '0;
            ack_cnt_q     <= '0;
            pending_q     <= '0;
            sound_code_q  <= '0;
            play_sound_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            play_sound_q <= 1'b0;
            if (clr_err_i) timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The winner is taken from the pending set the ISSUE cycle will see.
                    if ((pending_q != '0) && !mute_i) begin
                        state_q      <= S_ISSUE;
                        play_sound_q <= 1'b1;
                        sound_code_q <= top_code(pending_d);
                    end
                end
                S_ISSUE: begin
                    state_q   <= S_WAIT_ACK;
                    ack_cnt_q <= '0;
                end
                S_WAIT_ACK: begin
                    if (player_busy_i) begin
                        state_q <= S_PLAYING;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_GAP;
                        gap_cnt_q     <= '0;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                S_PLAYING: begin
                    if (!player_busy_i) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sound_code_o  = sound_code_q;
    assign play_sound_o  = play_sound_q;
    assign pending_o     = pending_q;
    assign timeout_err_o = timeout_err_q;
    assign sched_busy_o  = (state_q != S_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Bench for sound_event_scheduler: time-based reference model checked every cycle,
// a table of pending-set vectors, directed corner sequences and a randomized run.
module tb_sound_event_scheduler;
    localparam int GAP = 4;
    localparam int ACK = 8;
    localparam int INF = 32'h3fffffff;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] req = '0;
    logic       mute = 1'b0;
    logic       player_busy = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] sound_code;
    logic       play_sound;
    logic [6:0] pending;
    logic       sched_busy;
    logic       timeout_err;

    always #5 clk = ~clk;

    sound_event_scheduler #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .rstn(rstn), .req_i(req), .mute_i(mute),
        .player_busy_i(player_busy), .clr_err_i(clr_err),
        .sound_code_o(sound_code), .play_sound_o(play_sound), .pending_o(pending),
        .sched_busy_o(sched_busy), .timeout_err_o(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit force_busy = 0;
    bit player_dead = 0;
    int pl_cnt = 0;
    int pl_hold = 20;

    // Reference model: pending set plus the cycle at which the scheduler is next free.
    int         cyc = 0;
    int         m_ready = 0;
    int         m_issue = 0;
    bit         m_waiting = 0;
    bit         m_playing = 0;
    logic [6:0] m_pend = '0;
    logic       m_play = 1'b0;
    logic [2:0] m_code = '0;
    logic       m_terr = 1'b0;

    typedef struct {
        logic [6:0] req;
        logic       mute;
        logic [6:0] exp_pend;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] highest(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 7; i++) if (v[i]) r = 3'(i + 1);
        return r;
    endfunction

    task automatic model_reset();
        m_ready = cyc; m_issue = 0; m_waiting = 0; m_playing = 0;
        m_pend = '0; m_play = 1'b0; m_code = '0; m_terr = 1'b0;
    endtask

    task automatic check_model();
        chk("play_sound", 32'(play_sound), 32'(m_play));
        chk("sound_code", 32'(sound_code), 32'(m_code));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("sched_busy", 32'(sched_busy), 32'((m_pend != '0) || (cyc < m_ready)));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic model_step();
        logic [6:0] clear;
        logic [6:0] np;
        bit         tevent;
        bit         nplay;
        tevent = 0;
        if (m_waiting) begin
            if (player_busy) begin
                m_waiting = 0; m_playing = 1;
            end else if (cyc == m_issue + ACK) begin
                m_waiting = 0; tevent = 1; m_ready = cyc + GAP + 1;
            end
        end else if (m_playing && !player_busy) begin
            m_playing = 0; m_ready = cyc + GAP + 1;
        end
        if (m_play) begin
            m_waiting = 1; m_issue = cyc;
        end
        clear = m_play ? (7'd1 << (m_code - 3'd1)) : 7'd0;
        if (mute) np = '0;
        else if (req[6]) np = 7'b1000000;
        else np = (m_pend | req) & ~clear;
        nplay = (cyc >= m_ready) && (m_pend != '0) && !mute;
        if (nplay) begin
            m_ready = INF;
            m_code  = highest(np);
        end
        if (tevent) m_terr = 1'b1;
        else if (clr_err) m_terr = 1'b0;
        m_pend = np;
        m_play = nplay;
        cyc++;
    endtask

    task automatic step();
        player_busy = force_busy || (pl_cnt > 0);
        if (pl_cnt > 0) pl_cnt--;
        if (play_sound && !player_dead) pl_cnt = pl_hold;
        model_step();
        @(posedge clk); #1;
        req = '0;
        clr_err = 1'b0;
        check_model();
    endtask

    task automatic wait_play(input int max, output logic [2:0] code);
        bit got;
        got = 0;
        code = '0;
        for (int i = 0; i < max; i++) begin
            step();
            if (play_sound) begin
                got = 1; code = sound_code; break;
            end
        end
        chk("wait_play in time", 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!sched_busy) break;
            step();
        end
        chk("idle reached", 32'(sched_busy), 32'd0);
    endtask

    task automatic count_plays(input int n, input logic [2:0] code, output int total, output int hits);
        total = 0; hits = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (play_sound) begin
                total++;
                if (sound_code == code) hits++;
            end
        end
    endtask

    initial begin
        logic [2:0] c;
        logic [6:0] r;
        int total, hits, k;

        tbl[0]  = '{7'b0000001, 1'b0, 7'b0000001};
        tbl[1]  = '{7'b0000100, 1'b0, 7'b0000101};
        tbl[2]  = '{7'b0000100, 1'b0, 7'b0000101};
        tbl[3]  = '{7'b0000000, 1'b0, 7'b0000101};
        tbl[4]  = '{7'b0100000, 1'b0, 7'b0100101};
        tbl[5]  = '{7'b1000000, 1'b0, 7'b1000000};
        tbl[6]  = '{7'b0000010, 1'b0, 7'b1000010};
        tbl[7]  = '{7'b0000000, 1'b1, 7'b0000000};
        tbl[8]  = '{7'b0011000, 1'b1, 7'b0000000};
        tbl[9]  = '{7'b0011000, 1'b0, 7'b0011000};
        tbl[10] = '{7'b1000001, 1'b0, 7'b1000000};
        tbl[11] = '{7'b0000000, 1'b1, 7'b0000000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset play", 32'(play_sound), 32'd0);
        chk("reset code", 32'(sound_code), 32'd0);
        chk("reset pending", 32'(pending), 32'd0);
        chk("reset sched_busy", 32'(sched_busy), 32'd0);
        chk("reset timeout_err", 32'(timeout_err), 32'd0);
        rstn = 1'b1;
        model_reset();

        // Single request: issue two cycles later.
        req = 7'b0000100;
        step();
        step();
        chk("A play latency", 32'(play_sound), 32'd1);
        chk("A code", 32'(sound_code), 32'd3);
        wait_idle(100);

        // Two codes together: higher first, lower after the gap.
        req = 7'b0010001;
        wait_play(10, c);
        chk("B first code", 32'(c), 32'd5);
        wait_play(100, c);
        chk("B second code", 32'(c), 32'd1);
        wait_idle(100);
        chk("B pending empty", 32'(pending), 32'd0);

        // Repeated request during playback coalesces into one replay.
        req = 7'b0000010;
        wait_play(10, c);
        chk("C first code", 32'(c), 32'd2);
        repeat (3) step();
        req = 7'b0000100; step();
        step();
        req = 7'b0000100; step();
        req = 7'b0000100; step();
        count_plays(80, 3'd3, total, hits);
        chk("C total plays", 32'(total), 32'd1);
        chk("C code3 plays", 32'(hits), 32'd1);
        wait_idle(100);

        // Pending-set vector table while the player is held busy.
        req = 7'b0000001;
        wait_play(10, c);
        force_busy = 1;
        step();
        for (int i = 0; i < 12; i++) begin
            req  = tbl[i].req;
            mute = tbl[i].mute;
            step();
            chk($sformatf("tbl[%0d] pending", i), 32'(pending), 32'(tbl[i].exp_pend));
            chk($sformatf("tbl[%0d] sched_busy", i), 32'(sched_busy), 32'd1);
            chk($sformatf("tbl[%0d] play", i), 32'(play_sound), 32'd0);
        end
        mute = 1'b0;
        force_busy = 0;
        wait_idle(100);

        // Game-over flushes lower pending codes.
        req = 7'b0000001;
        wait_play(10, c);
        force_busy = 1;
        step();
        req = 7'b0000011; step();
        chk("D pending before flush", 32'(pending), 32'h03);
        req = 7'b1000000; step();
        chk("D pending after flush", 32'(pending), 32'h40);
        force_busy = 0;
        count_plays(80, 3'd7, total, hits);
        chk("D total plays", 32'(total), 32'd1);
        chk("D code7 plays", 32'(hits), 32'd1);
        wait_idle(100);

        // Player never acknowledges: sticky error, then cleared.
        player_dead = 1;
        req = 7'b0001000;
        wait_play(10, c);
        chk("E code", 32'(c), 32'd4);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            k = i;
            if (timeout_err) break;
        end
        chk("E timeout latency", 32'(k), 32'(ACK + 1));
        wait_idle(40);
        chk("E error sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        step();
        chk("E error cleared", 32'(timeout_err), 32'd0);
        player_dead = 0;

        // Mute during playback: effect finishes, pending discarded, nothing new issued.
        req = 7'b0000010;
        wait_play(10, c);
        step();
        req = 7'b0000110; step();
        chk("F pending before mute", 32'(pending), 32'h06);
        mute = 1'b1;
        step();
        chk("F pending muted", 32'(pending), 32'd0);
        count_plays(60, 3'd0, total, hits);
        chk("F no plays while muted", 32'(total), 32'd0);
        chk("F idle while muted", 32'(sched_busy), 32'd0);
        mute = 1'b0;

        // Asynchronous reset in the middle of the silence gap.
        req = 7'b0000001;
        wait_play(10, c);
        repeat (23) step();
        chk("G code before reset", 32'(sound_code), 32'd1);
        chk("G busy before reset", 32'(sched_busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("G reset play", 32'(play_sound), 32'd0);
        chk("G reset code", 32'(sound_code), 32'd0);
        chk("G reset pending", 32'(pending), 32'd0);
        chk("G reset sched_busy", 32'(sched_busy), 32'd0);
        chk("G reset timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        chk("G held code", 32'(sound_code), 32'd0);
        rstn = 1'b1;
        pl_cnt = 0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 7'($urandom());
                if ($urandom_range(0, 3) != 0) r[6] = 1'b0;
                req = r;
            end
            if ($urandom_range(0, 40) == 0) mute = ~mute;
            clr_err = ($urandom_range(0, 15) == 0);
            pl_hold = $urandom_range(1, 12);
            player_dead = ($urandom_range(0, 5) == 0);
            step();
        end
        mute = 1'b0;
        player_dead = 0;
        pl_hold = 20;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
